// File: rtl/inst_buff_pkg.sv
// Shared fetch/dispatch definitions: instruction packet, branch task and
// the widths that fetch and the instruction buffer must agree on.
package inst_buff_pkg;

  localparam int DISPATCH_N  = 3;
  localparam int IBUFF_DEPTH = 8;
  localparam int FETCH_WIDTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } INST_PACKET;

  typedef enum logic [1:0] {
    BR_NOTHING  = 2'd0,
    SQUASH      = 2'd1,
    BR_PREDICT  = 2'd2,
    BR_RESOLVE  = 2'd3
  } BR_TASK;

endpackage

// File: rtl/inst_buff_if.sv
// Fetch-side and dispatch-side signals of the instruction buffer.
interface inst_buff_if #(
  parameter int N     = inst_buff_pkg::DISPATCH_N,
  parameter int DEPTH = inst_buff_pkg::IBUFF_DEPTH
);
  import inst_buff_pkg::*;

  INST_PACKET [FETCH_WIDTH-1:0]       in_insts;
  logic [2:0]                         in_num_insts;
  logic [$clog2(N+1)-1:0]             dispatch_open;
  INST_PACKET [N-1:0]                 out_insts;
  logic [$clog2(N+1)-1:0]             out_num_insts;
  logic [$clog2(DEPTH+1)-1:0]         ibuff_open;

  modport master (
    output in_insts, in_num_insts, dispatch_open,
    input  out_insts, out_num_insts, ibuff_open
  );

  modport slave (
    input  in_insts, in_num_insts, dispatch_open,
    output out_insts, out_num_insts, ibuff_open
  );

endinterface

// File: rtl/inst_buff_ptr_wrap_add.sv
// Circular pointer adder: (ptr + inc) mod DEPTH for inc <= DEPTH, using a
// single compare-and-subtract so non-power-of-two depths wrap correctly.
module ptr_wrap_add #(
  parameter int DEPTH = 8,
  parameter int INC_W = 3,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [INC_W-1:0] inc,
  output logic [PTR_W-1:0] sum
);

  localparam int SUM_W = ((PTR_W > INC_W) ? PTR_W : INC_W) + 1;

  logic [SUM_W-1:0] raw;

  assign raw = SUM_W'(ptr) + SUM_W'(inc);
  assign sum = (raw >= SUM_W'(DEPTH)) ? PTR_W'(raw - SUM_W'(DEPTH)) : PTR_W'(raw);

endmodule

// File: rtl/inst_buff.sv
// Circular instruction buffer between fetch and dispatch with first-word
// fall-through output and a start-of-cycle free-entry count for fetch.
module inst_buff
  import inst_buff_pkg::*;
#(
  parameter int N               = DISPATCH_N,
  parameter int INST_BUFF_DEPTH = IBUFF_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  BR_TASK      br_task,
  inst_buff_if.slave  bus
);

  localparam int PTR_W = $clog2(INST_BUFF_DEPTH);
  localparam int CNT_W = $clog2(INST_BUFF_DEPTH + 1);
  localparam int OUT_W = $clog2(N + 1);
  localparam int ACC_W = $clog2(FETCH_WIDTH + 1);

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  INST_PACKET       entries [INST_BUFF_DEPTH];
  logic [PTR_W-1:0] head, tail, head_next, tail_next;
  logic [CNT_W-1:0] count, free_slots;
  logic [OUT_W-1:0] out_num;
  logic [ACC_W-1:0] accepted;
  logic [PTR_W-1:0] rd_idx [N];
  logic [PTR_W-1:0] wr_idx [FETCH_WIDTH];
  logic             squash;

  assign squash     = (br_task == SQUASH);
  assign free_slots = CNT_W'(INST_BUFF_DEPTH) - count;

  // Space is judged at start of cycle; slots freed by this cycle's dequeue wait a cycle.
  assign out_num  = squash ? '0 :
                    OUT_W'(min_int(min_int(int'(bus.dispatch_open), int'(count)), N));
  assign accepted = squash ? '0 :
                    ACC_W'(min_int(int'(bus.in_num_insts), int'(free_slots)));

  assign bus.out_num_insts = out_num;
  assign bus.ibuff_open    = free_slots;

  for (genvar i = 0; i < N; i++) begin : g_rd
    ptr_wrap_add #(.DEPTH(INST_BUFF_DEPTH), .INC_W(OUT_W)) u_rd_idx (
      .ptr (head),
      .inc (OUT_W'(i)),
      .sum (rd_idx[i])
    );
    assign bus.out_insts[i] = (OUT_W'(i) < out_num) ? entries[rd_idx[i]] : '0;
  end

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_wr
    ptr_wrap_add #(.DEPTH(INST_BUFF_DEPTH), .INC_W(ACC_W)) u_wr_idx (
      .ptr (tail),
      .inc (ACC_W'(i)),
      .sum (wr_idx[i])
    );
  end

  ptr_wrap_add #(.DEPTH(INST_BUFF_DEPTH), .INC_W(OUT_W)) u_head_add (
    .ptr (head),
    .inc (out_num),
    .sum (head_next)
  );

  ptr_wrap_add #(.DEPTH(INST_BUFF_DEPTH), .INC_W(ACC_W)) u_tail_add (
    .ptr (tail),
    .inc (accepted),
    .sum (tail_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < INST_BUFF_DEPTH; k++) entries[k] <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count + CNT_W'(accepted) - CNT_W'(out_num);
      // Packets inside the in_num_insts range are stored even when valid=0.
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (ACC_W'(i) < accepted) entries[wr_idx[i]] <= bus.in_insts[i];
      end
    end
  end

  always @(posedge clock) begin
    if (reset && !squash) begin
      assert (int'(bus.in_num_insts) <= int'(free_slots))
        else $warning("inst_buff: fetch offered %0d packets with %0d free entries; excess dropped",
                      bus.in_num_insts, free_slots);
    end
  end

endmodule

// File: tb/tb_inst_buff.sv
// Randomised scoreboard bench for inst_buff: a queue models buffer contents,
// the driver pushes accepted packets and the monitor pops what dispatch takes.
module tb_inst_buff;
  import inst_buff_pkg::*;

  localparam int N = 3;
  localparam int D = 8;

  logic   clock;
  logic   reset;
  BR_TASK br_task;

  inst_buff_if #(.N(N), .DEPTH(D)) bus ();

  inst_buff #(.N(N), .INST_BUFF_DEPTH(D)) dut (
    .clock   (clock),
    .reset   (reset),
    .br_task (br_task),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  INST_PACKET  sb [$];
  int          checks;
  int          errors;
  logic [31:0] next_pc;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: sample mid low-phase, compare against the oldest queued packets.
  always @(negedge clock) begin
    int exp_n;
    int exp_open;
    #2;
    if (!reset) begin
      chk("reset_out_num", 65'(bus.out_num_insts), 65'(0));
      chk("reset_ibuff_open", 65'(bus.ibuff_open), 65'(D));
      for (int i = 0; i < N; i++) chk($sformatf("reset_out_slot%0d", i), bus.out_insts[i], 65'(0));
    end else begin
      exp_open = D - sb.size();
      exp_n = (br_task == SQUASH) ? 0 : imin(imin(sb.size(), int'(bus.dispatch_open)), N);
      chk("ibuff_open", 65'(bus.ibuff_open), 65'(exp_open));
      chk("out_num_insts", 65'(bus.out_num_insts), 65'(exp_n));
      for (int i = 0; i < N; i++) begin
        if (i < exp_n) chk($sformatf("out_slot%0d", i), bus.out_insts[i], sb[i]);
        else           chk($sformatf("idle_slot%0d", i), bus.out_insts[i], 65'(0));
      end
      for (int i = 0; i < exp_n; i++) void'(sb.pop_front());
    end
  end

  // One cycle of stimulus; the model update lands after the monitor has sampled.
  task automatic drive_cycle(input bit sq, input int n_in, input int disp, input bit rst_mid);
    int space;
    int acc;
    INST_PACKET pkt;
    @(negedge clock);
    space = D - sb.size();
    acc   = (sq || !reset) ? 0 : imin(n_in, space);
    br_task = sq ? SQUASH : BR_NOTHING;
    bus.in_num_insts  = 3'(n_in);
    bus.dispatch_open = 2'(disp);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pkt.valid = 1'($urandom_range(0, 1));
      pkt.inst  = $urandom;
      if (i < acc) begin
        pkt.pc  = next_pc;
        next_pc = next_pc + 32'd4;
      end else begin
        pkt.pc  = 32'hDEAD_0000 + 32'(i);
      end
      bus.in_insts[i] = pkt;
    end
    if (rst_mid) begin
      #1 reset = 1'b0;
      #2;
    end else begin
      #3;
    end
    if (!reset || sq) sb.delete();
    else for (int i = 0; i < acc; i++) sb.push_back(bus.in_insts[i]);
  endtask

  task automatic release_reset();
    bus.in_num_insts = 3'd0;
    reset = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    next_pc = 32'h0;
    reset   = 1'b0;
    br_task = BR_NOTHING;
    bus.in_num_insts  = 3'd4;
    bus.dispatch_open = 2'd3;
    for (int i = 0; i < FETCH_WIDTH; i++) bus.in_insts[i] = INST_PACKET'($urandom);

    // Reset held with fetch offering packets, then an idle cycle.
    drive_cycle(1'b0, 4, 3, 1'b0);
    drive_cycle(1'b0, 4, 3, 1'b0);
    release_reset();
    drive_cycle(1'b0, 0, 3, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);

    // Basic enqueue, partial and trailing dequeue.
    drive_cycle(1'b0, 4, 0, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);

    // Fill, then overrun while full.
    drive_cycle(1'b0, 4, 0, 1'b0);
    drive_cycle(1'b0, 4, 0, 1'b0);
    drive_cycle(1'b0, 2, 3, 1'b0);
    drive_cycle(1'b0, 0, 0, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);

    // Steady enqueue 4 / dequeue 3 across pointer wrap.
    for (int c = 0; c < 10; c++) drive_cycle(1'b0, imin(4, D - sb.size()), 3, 1'b0);
    for (int c = 0; c < 4; c++) drive_cycle(1'b0, 0, 3, 1'b0);

    // Squash with 5 entries, then refill from a new PC.
    drive_cycle(1'b0, 4, 0, 1'b0);
    drive_cycle(1'b0, 1, 0, 1'b0);
    drive_cycle(1'b1, 4, 3, 1'b0);
    drive_cycle(1'b0, 0, 3, 1'b0);
    next_pc = 32'h100;
    drive_cycle(1'b0, 1, 0, 1'b0);
    drive_cycle(1'b0, 0, 1, 1'b0);

    // Asynchronous reset mid-cycle with 6 entries.
    drive_cycle(1'b0, 4, 0, 1'b0);
    drive_cycle(1'b0, 2, 0, 1'b0);
    drive_cycle(1'b0, 0, 0, 1'b1);
    drive_cycle(1'b0, 4, 3, 1'b0);
    release_reset();
    drive_cycle(1'b0, 0, 3, 1'b0);

    // Random traffic with occasional squash and reset.
    for (int c = 0; c < 400; c++) begin
      int r;
      r = $urandom_range(0, 99);
      drive_cycle(r < 5, $urandom_range(0, imin(4, D - sb.size())), $urandom_range(0, 3), r == 99);
      if (!reset) release_reset();
    end
    drive_cycle(1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
